// File: rtl/gain_stage_arb_pkg.sv
// rtl/gain_stage_arb_pkg.sv - shared FSM type and constants for gain_stage_arb
package gain_stage_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   // Unity gain with a 12-bit fractional shift in the downstream gain_stage
   localparam int UNITY_GAIN             = 'h1000;
   localparam int DEFAULT_TIMEOUT_CYCLES = 100;

endpackage

// File: rtl/gain_stage_arb_rr_arbiter.sv
// rtl/gain_stage_arb_rr_arbiter.sv - round-robin selector, priority starts at ptr_i
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic              valid_o
);

   logic [CH_W:0] idx;

   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = {1'b0, ptr_i} + (CH_W+1)'(i);
         if (idx >= (CH_W+1)'(NUM_CH)) begin
            idx = idx - (CH_W+1)'(NUM_CH);
         end
         if (!valid_o && req_i[idx[CH_W-1:0]]) begin
            grant_o[idx[CH_W-1:0]] = 1'b1;
            valid_o                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gain_stage_arb.sv
// rtl/gain_stage_arb.sv - arbitrates NUM_CH requesters onto one shared gain_stage
// Optional WAIT timeout enabled by defining GAIN_STAGE_ARB_TIMEOUT_EN.
module gain_stage_arb
   import gain_stage_arb_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int GAIN_WIDTH     = 16,
   parameter int DIN_WIDTH      = 16,
   parameter int DOUT_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             req,
   input  logic [NUM_CH*DIN_WIDTH-1:0]   req_din,
   output logic [NUM_CH-1:0]             ack,
   input  logic                          cfg_we,
   input  logic [$clog2(NUM_CH)-1:0]     cfg_ch,
   input  logic [GAIN_WIDTH-1:0]         cfg_gain,
   output logic [GAIN_WIDTH-1:0]         gs_gain,
   output logic [DIN_WIDTH-1:0]          gs_din,
   output logic                          gs_din_v,
   input  logic [DOUT_WIDTH-1:0]         gs_dout,
   input  logic                          gs_dout_v,
   output logic                          rsp_v,
   output logic [$clog2(NUM_CH)-1:0]     rsp_ch,
   output logic [DOUT_WIDTH-1:0]         rsp_dout,
   output logic                          rsp_err,
   output logic                          busy
);

   localparam int CH_W = $clog2(NUM_CH);

   state_e                 state_q, state_d;
   logic [CH_W-1:0]        ptr_q, ptr_d;
   logic [CH_W-1:0]        ch_q, ch_d;
   logic [DIN_WIDTH-1:0]   din_q, din_d;
   logic [GAIN_WIDTH-1:0]  gain_lat_q, gain_lat_d;
   logic [GAIN_WIDTH-1:0]  gain_q [NUM_CH];
   logic                   rsp_v_q, rsp_v_d;
   logic [CH_W-1:0]        rsp_ch_q, rsp_ch_d;
   logic [DOUT_WIDTH-1:0]  rsp_dout_q, rsp_dout_d;

   logic [NUM_CH-1:0]      grant;
   logic                   grant_v;
   logic [CH_W-1:0]        grant_idx;

`ifdef GAIN_STAGE_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rsp_err_q, rsp_err_d;
`endif

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rr (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .valid_o (grant_v)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) begin
            grant_idx = CH_W'(i);
         end
      end
   end

   // Gain registers are read in IDLE before a same-edge write lands
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            gain_q[k] <= GAIN_WIDTH'(UNITY_GAIN);
         end
      end else if (cfg_we) begin
         gain_q[cfg_ch] <= cfg_gain;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      ch_d       = ch_q;
      din_d      = din_q;
      gain_lat_d = gain_lat_q;
      rsp_v_d    = 1'b0;
      rsp_ch_d   = rsp_ch_q;
      rsp_dout_d = rsp_dout_q;
`ifdef GAIN_STAGE_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      rsp_err_d  = rsp_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant_v) begin
               ch_d       = grant_idx;
               din_d      = req_din[grant_idx*DIN_WIDTH +: DIN_WIDTH];
               gain_lat_d = gain_q[grant_idx];
               ptr_d      = (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
`ifdef GAIN_STAGE_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (gs_dout_v) begin
               rsp_v_d    = 1'b1;
               rsp_ch_d   = ch_q;
               rsp_dout_d = gs_dout;
`ifdef GAIN_STAGE_ARB_TIMEOUT_EN
               rsp_err_d  = 1'b0;
`endif
               state_d    = ST_IDLE;
            end
`ifdef GAIN_STAGE_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
               rsp_v_d    = 1'b1;
               rsp_ch_d   = ch_q;
               rsp_dout_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         ch_q       <= '0;
         din_q      <= '0;
         gain_lat_q <= '0;
         rsp_v_q    <= 1'b0;
         rsp_ch_q   <= '0;
         rsp_dout_q <= '0;
`ifdef GAIN_STAGE_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         ch_q       <= ch_d;
         din_q      <= din_d;
         gain_lat_q <= gain_lat_d;
         rsp_v_q    <= rsp_v_d;
         rsp_ch_q   <= rsp_ch_d;
         rsp_dout_q <= rsp_dout_d;
`ifdef GAIN_STAGE_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         rsp_err_q  <= rsp_err_d;
`endif
      end
   end

   assign gs_din_v = (state_q == ST_ISSUE);
   assign ack      = (state_q == ST_ISSUE) ? (NUM_CH'(1) << ch_q) : '0;
   assign gs_din   = din_q;
   assign gs_gain  = gain_lat_q;
   assign busy     = (state_q != ST_IDLE);
   assign rsp_v    = rsp_v_q;
   assign rsp_ch   = rsp_ch_q;
   assign rsp_dout = rsp_dout_q;
`ifdef GAIN_STAGE_ARB_TIMEOUT_EN
   assign rsp_err  = rsp_err_q;
`else
   assign rsp_err  = 1'b0;
`endif

endmodule

// File: doc/gain_stage_arb.md
GAIN_STAGE_ARB -- requirements
Module: gain_stage_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels.
REQ-002 SHALL have parameter GAIN_WIDTH, default 16: per-channel gain width.
REQ-003 SHALL have parameter DIN_WIDTH, default 16: sample input width.
REQ-004 SHALL have parameter DOUT_WIDTH, default 16: gain_stage output width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 100: WAIT-state limit.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port req, input, NUM_CH: per-channel request, level, held until ack.
REQ-009 SHALL have port req_din, input, NUM_CH*DIN_WIDTH: per-channel sample; channel k in slice k.
REQ-010 SHALL have port ack, output, NUM_CH: one-cycle one-hot pulse when a channel's sample is issued.
REQ-011 SHALL have port cfg_we, input, 1: gain register write strobe.
REQ-012 SHALL have port cfg_ch, input, clog2(NUM_CH): gain register index.
REQ-013 SHALL have port cfg_gain, input, GAIN_WIDTH: gain write data.
REQ-014 SHALL have ports gs_gain (GAIN_WIDTH), gs_din (DIN_WIDTH) and gs_din_v (1), outputs: drive the shared gain_stage.
REQ-015 SHALL have ports gs_dout (DOUT_WIDTH) and gs_dout_v (1), inputs: result from the shared gain_stage.
REQ-016 SHALL have ports rsp_v (1), rsp_ch (clog2(NUM_CH)), rsp_dout (DOUT_WIDTH) and rsp_err (1), outputs: response to the requester.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-018 SHALL hold NUM_CH gain registers, each reset to 'h1000 (unity for SHIFT_LEFT_SIZE=12); cfg_we writes cfg_gain into register cfg_ch at the next edge.
REQ-019 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> IDLE, with at most one transaction outstanding.
REQ-020 In IDLE with any req bit high, SHALL select round-robin, starting at the channel after the last granted channel (channel 0 after reset), latch the channel, req_din slice and gain register, and go to ISSUE.
REQ-021 In ISSUE, SHALL assert gs_din_v and the matching ack bit for exactly one cycle, with gs_din and gs_gain held at the latched values, then go to WAIT.
REQ-022 In WAIT on gs_dout_v, SHALL register gs_dout into rsp_dout with rsp_ch=latched channel, rsp_err=0, rsp_v pulsed for one cycle, and return to IDLE; latency req->rsp_v = 2 cycles + gain_stage latency + 1 cycle.
REQ-023 SHALL ignore gs_dout_v outside WAIT.
REQ-024 SHALL let a cfg write to the channel being issued in the same cycle affect only later transactions, since the gain is latched in IDLE.
REQ-025 SHALL issue a back-to-back request no earlier than the cycle after rsp_v (IDLE evaluation).
REQ-026 SHALL stay idle while req is all zeros, with outputs at reset values.

Reset
REQ-027 On rst, SHALL enter IDLE; ack=0, gs_din_v=0, gs_din=0, gs_gain=0, rsp_v=0, rsp_ch=0, rsp_dout=0, rsp_err=0, busy=0, round-robin pointer=0, gain registers='h1000.
REQ-028 On rst mid-transaction, SHALL drop the outstanding transaction with no rsp_v, and ignore a subsequent gs_dout_v.

Configuration
REQ-029 With GAIN_STAGE_ARB_TIMEOUT_EN defined, SHALL count WAIT cycles and, on reaching TIMEOUT_CYCLES, pulse rsp_v with rsp_err=1 and rsp_dout=0, then return to IDLE.
REQ-030 Without GAIN_STAGE_ARB_TIMEOUT_EN, SHALL wait indefinitely in WAIT, omit the counter and tie rsp_err to 0.

Structure
REQ-031 Package gain_stage_arb_pkg SHALL hold the FSM state enum, the unity-gain constant 'h1000 and the default TIMEOUT_CYCLES.
REQ-032 The round-robin selection SHALL be a sub-module rr_arbiter (inputs req and last-grant pointer; outputs one-hot grant and valid).

Verification
REQ-033 Reset defaults: ch0 gain default, req=0001, din=1234, stage gain_stage(12) -> rsp_v, rsp_ch=0, rsp_dout=1234±1, rsp_err=0.
REQ-034 Fairness: req=1111 held, reasserted after each ack -> ack order 0,1,2,3,0; no channel granted twice in a row.
REQ-035 Cfg update: write ch2 gain='h2000 while ch2 is in WAIT with gain 'h1000, din=1000 -> first rsp_dout=1000, next rsp_dout=2000.
REQ-036 Saturation: ch1 gain='h1FFF, din=49900 -> rsp_dout=65535.
REQ-037 Timeout (macro defined): stage model never asserts gs_dout_v -> rsp_v with rsp_err=1 exactly TIMEOUT_CYCLES=100 cycles after entering WAIT; next request serviced normally.
REQ-038 Reset in WAIT: rst for 1 cycle, then stage returns gs_dout_v -> no rsp_v, busy=0, next grant goes to channel 0.
